// File: rtl/panda_pkg.sv
// panda_pkg: shared types for the panda load/store unit
package panda_pkg;
  typedef enum logic [1:0] {MemByte = 2'b00, MemHalf = 2'b01, MemWord = 2'b10} mem_size_e;
  typedef enum logic [1:0] {LsuIdle, LsuAccess, LsuCapture, LsuResp} lsu_state_e;
endpackage

// File: rtl/panda_lsu_if.sv
// panda_lsu_if: core-side request/response handshake of the load/store unit
interface panda_lsu_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) ();
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [1:0]           req_size_i;
  logic                 req_unsigned_i;
  logic [AddrWidth-1:0] req_addr_i;
  logic [DataWidth-1:0] req_wdata_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DataWidth-1:0] rsp_rdata_o;
  logic                 rsp_err_o;
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/panda_load_align.sv
// panda_load_align: picks the addressed byte/half out of a RAM word and extends it
module panda_load_align
  import panda_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o
);
  logic [31:0] sh;
  assign sh = raw_i >> {off_i, 3'b000};
  // sign bit is masked off for unsigned loads so one expression covers both
  always_comb
    data_o = size_i == MemByte ? {{24{~uns_i & sh[7]}}, sh[7:0]} :
             size_i == MemHalf ? {{16{~uns_i & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/panda_lsu.sv
// panda_lsu: single-outstanding load/store unit in front of panda_ram
module panda_lsu
  import panda_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 64,
  parameter int AddrWidth = 32,
  localparam int RamAw    = $clog2(Depth)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  panda_lsu_if.slave             bus,
  output logic                   ram_ce_o,
  output logic [DataWidth/8-1:0] ram_we_o,
  output logic [RamAw-1:0]       ram_addr_o,
  output logic [DataWidth-1:0]   ram_wdata_o,
  input  logic [DataWidth-1:0]   ram_rdata_i
);
  lsu_state_e             state_q, state_d;
  logic [1:0]             size_q, size_d, off_q, off_d;
  logic                   uns_q, uns_d, err_q, err_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d, aligned;
  logic                   ram_ce_q, ram_ce_d;
  logic [DataWidth/8-1:0] ram_we_q, ram_we_d;
  logic [RamAw-1:0]       ram_addr_q, ram_addr_d;
  logic [DataWidth-1:0]   ram_wdata_q, ram_wdata_d;
  logic                   req_err, req_store;
  logic [3:0]             lanes;
  logic [DataWidth-1:0]   rep;
  assign req_err = bus.req_size_i == 2'b11 ||
                   (bus.req_size_i == MemHalf && bus.req_addr_i[0]) ||
                   (bus.req_size_i == MemWord && |bus.req_addr_i[1:0]) ||
                   bus.req_addr_i[AddrWidth-1:2] >= (AddrWidth-2)'(Depth);
  assign req_store = bus.req_we_i & ~req_err;
  assign lanes = (bus.req_size_i == MemByte ? 4'b0001 :
                  bus.req_size_i == MemHalf ? 4'b0011 : 4'b1111) << bus.req_addr_i[1:0];
  assign rep = bus.req_size_i == MemByte ? {4{bus.req_wdata_i[7:0]}} :
               bus.req_size_i == MemHalf ? {2{bus.req_wdata_i[15:0]}} : bus.req_wdata_i;
  panda_load_align u_align (
    .off_i  (off_q),
    .size_i (size_q),
    .uns_i  (uns_q),
    .raw_i  (ram_rdata_i),
    .data_o (aligned)
  );
  // next state; RAM controls are computed one cycle early so they are registered in ACCESS
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    ram_ce_d    = 1'b0;
    ram_we_d    = '0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    unique case (state_q)
      LsuIdle: if (bus.req_valid_i) begin
        state_d     = req_err ? LsuResp : LsuAccess;
        size_d      = bus.req_size_i;
        off_d       = bus.req_addr_i[1:0];
        uns_d       = bus.req_unsigned_i;
        err_d       = req_err;
        rdata_d     = '0;
        ram_ce_d    = ~req_err;
        ram_we_d    = req_store ? lanes : '0;
        ram_addr_d  = req_err ? '0 : bus.req_addr_i[2+:RamAw];
        ram_wdata_d = req_store ? rep : '0;
      end
      LsuAccess:  state_d = |ram_we_q ? LsuResp : LsuCapture;
      LsuCapture: begin
        rdata_d = aligned;
        state_d = LsuResp;
      end
      LsuResp:    state_d = bus.rsp_ready_i ? LsuIdle : LsuResp;
      default:    state_d = LsuIdle;
    endcase
  end
  // state and datapath registers; async reset also drops any RAM access in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= LsuIdle;
      size_q      <= '0;
      off_q       <= '0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end
  assign bus.req_ready_o = state_q == LsuIdle;
  assign bus.rsp_valid_o = state_q == LsuResp;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
  assign ram_ce_o        = ram_ce_q;
  assign ram_we_o        = ram_we_q;
  assign ram_addr_o      = ram_addr_q;
  assign ram_wdata_o     = ram_wdata_q;
endmodule

// File: tb/tb_panda_lsu.sv
// tb_panda_lsu: directed vector bench for panda_lsu with a behavioural panda_ram
module tb_panda_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  panda_lsu_if bus ();
  logic        ram_ce;
  logic [3:0]  ram_we;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [31:0] mem [64] = '{default: 32'h0};
  panda_lsu dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .ram_ce_o    (ram_ce),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );
  // synchronous RAM: byte-lane writes, read data one cycle after ce
  always @(posedge clk) if (ram_ce) begin
    for (int i = 0; i < 4; i++) if (ram_we[i]) mem[ram_addr][8*i+:8] <= ram_wdata[8*i+:8];
    ram_rdata <= mem[ram_addr];
  end
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        ce;
    logic [3:0]  rwe;
    logic [5:0]  raddr;
    logic [31:0] rwd;
  } vec_t;
  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output int lat, output logic [31:0] rdata, output logic err,
                      output logic ce, output logic [3:0] rwe, output logic [5:0] raddr,
                      output logic [31:0] rwd, output logic stray);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i = we;
    bus.req_size_i = size;
    bus.req_unsigned_i = uns;
    bus.req_addr_i = addr;
    bus.req_wdata_i = wdata;
    bus.rsp_ready_i = 1'b0;
    ce = 1'b0;
    rwe = '0;
    raddr = '0;
    rwd = '0;
    stray = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    lat = 1;
    while (!bus.rsp_valid_o && lat < 12) begin
      if (ram_ce) begin
        ce = 1'b1;
        rwe = ram_we;
        raddr = ram_addr;
        rwd = ram_wdata;
      end else if (ram_we != 0 || ram_addr != 0 || ram_wdata != 0) stray = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (ram_ce || ram_we != 0 || ram_addr != 0 || ram_wdata != 0) stray = 1'b1;
    rdata = bus.rsp_rdata_o;
    err = bus.rsp_err_o;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
  endtask
  vec_t vt [16];
  int lat;
  logic [31:0] rdata, rwd;
  logic err, ce, stray;
  logic [3:0] rwe;
  logic [5:0] raddr;
  initial begin
    vt[0]  = '{1'b1, 2'b10, 1'b0, 32'hA0,  32'hABCDEF89, 2, 32'h0,        1'b0, 1'b1, 4'hF, 6'd40, 32'hABCDEF89};
    vt[1]  = '{1'b0, 2'b00, 1'b0, 32'hA1,  32'h0,        3, 32'hFFFFFFEF, 1'b0, 1'b1, 4'h0, 6'd40, 32'h0};
    vt[2]  = '{1'b0, 2'b01, 1'b1, 32'hA2,  32'h0,        3, 32'h0000ABCD, 1'b0, 1'b1, 4'h0, 6'd40, 32'h0};
    vt[3]  = '{1'b0, 2'b10, 1'b0, 32'hA0,  32'h0,        3, 32'hABCDEF89, 1'b0, 1'b1, 4'h0, 6'd40, 32'h0};
    vt[4]  = '{1'b1, 2'b00, 1'b0, 32'hA7,  32'hDEAD0012, 2, 32'h0,        1'b0, 1'b1, 4'h8, 6'd41, 32'h12121212};
    vt[5]  = '{1'b1, 2'b01, 1'b0, 32'hA6,  32'hBEEF3456, 2, 32'h0,        1'b0, 1'b1, 4'hC, 6'd41, 32'h34563456};
    vt[6]  = '{1'b0, 2'b10, 1'b0, 32'hA4,  32'h0,        3, 32'h34560000, 1'b0, 1'b1, 4'h0, 6'd41, 32'h0};
    vt[7]  = '{1'b0, 2'b00, 1'b1, 32'hA7,  32'h0,        3, 32'h00000034, 1'b0, 1'b1, 4'h0, 6'd41, 32'h0};
    vt[8]  = '{1'b0, 2'b01, 1'b0, 32'hA2,  32'h0,        3, 32'hFFFFABCD, 1'b0, 1'b1, 4'h0, 6'd40, 32'h0};
    vt[9]  = '{1'b0, 2'b00, 1'b0, 32'hA3,  32'h0,        3, 32'hFFFFFFAB, 1'b0, 1'b1, 4'h0, 6'd40, 32'h0};
    vt[10] = '{1'b0, 2'b00, 1'b1, 32'hA0,  32'h0,        3, 32'h00000089, 1'b0, 1'b1, 4'h0, 6'd40, 32'h0};
    vt[11] = '{1'b0, 2'b10, 1'b0, 32'hFC,  32'h0,        3, 32'h0,        1'b0, 1'b1, 4'h0, 6'd63, 32'h0};
    vt[12] = '{1'b0, 2'b01, 1'b0, 32'h03,  32'h0,        1, 32'h0,        1'b1, 1'b0, 4'h0, 6'd0,  32'h0};
    vt[13] = '{1'b0, 2'b10, 1'b0, 32'hA2,  32'h0,        1, 32'h0,        1'b1, 1'b0, 4'h0, 6'd0,  32'h0};
    vt[14] = '{1'b0, 2'b11, 1'b0, 32'hA0,  32'h0,        1, 32'h0,        1'b1, 1'b0, 4'h0, 6'd0,  32'h0};
    vt[15] = '{1'b1, 2'b10, 1'b0, 32'h100, 32'hFFFFFFFF, 1, 32'h0,        1'b1, 1'b0, 4'h0, 6'd0,  32'h0};
    bus.req_valid_i = 1'b0;
    bus.req_we_i = 1'b0;
    bus.req_size_i = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i = '0;
    bus.req_wdata_i = '0;
    bus.rsp_ready_i = 1'b0;
    #12;
    chk("reset_req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata_o, 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err_o), 32'd0);
    chk("reset_ram_ctl", {27'd0, ram_ce, ram_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      xact(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, lat, rdata, err, ce, rwe, raddr, rwd, stray);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_rdata", i), rdata, vt[i].rdata);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].err));
      chk($sformatf("v%0d_ram_ce_seen", i), 32'(ce), 32'(vt[i].ce));
      chk($sformatf("v%0d_ram_idle_zero", i), 32'(stray), 32'd0);
      if (vt[i].ce) begin
        chk($sformatf("v%0d_ram_we", i), 32'(rwe), 32'(vt[i].rwe));
        chk($sformatf("v%0d_ram_addr", i), 32'(raddr), 32'(vt[i].raddr));
        chk($sformatf("v%0d_ram_wdata", i), rwd, vt[i].rwd);
      end
    end
    // response back-pressure: output must hold while rsp_ready_i stays low
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i = 1'b0;
    bus.req_size_i = 2'b10;
    bus.req_addr_i = 32'hA0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    for (int k = 0; k < 10 && !bus.rsp_valid_o; k++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d_rsp_valid", k), 32'(bus.rsp_valid_o), 32'd1);
      chk($sformatf("hold%0d_rsp_rdata", k), bus.rsp_rdata_o, 32'hABCDEF89);
      chk($sformatf("hold%0d_req_ready", k), 32'(bus.req_ready_o), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    chk("hold_done_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("hold_done_req_ready", 32'(bus.req_ready_o), 32'd1);
    // reset during a store's ACCESS cycle must keep the write from landing
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i = 1'b1;
    bus.req_size_i = 2'b10;
    bus.req_addr_i = 32'hA0;
    bus.req_wdata_i = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("rst_access_ce", 32'(ram_ce), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_ram_ctl", {27'd0, ram_ce, ram_we}, 32'd0);
    chk("rst_async_ram_wdata", ram_wdata, 32'd0);
    chk("rst_async_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_release_req_ready", 32'(bus.req_ready_o), 32'd1);
    xact(1'b0, 2'b10, 1'b0, 32'hA0, 32'h0, lat, rdata, err, ce, rwe, raddr, rwd, stray);
    chk("rst_old_data_rdata", rdata, 32'hABCDEF89);
    chk("rst_old_data_latency", 32'(lat), 32'd3);
    chk("rst_old_data_err", 32'(err), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
